instruction_fetch_unit: RTL and testbench

Program-counter and fetch-control stage sitting directly upstream of the synchronous-read instruction memory. Drives the word address into the memory each cycle, tracks which address the returned word belongs to, and presents `{pc, instruction, valid}` to decode. Handles stall (hold), taken-branch redirect with zero bubble, and end-of-program halt. Memory is word-addressed: consecutive instructions are at consecutive addresses, and read data appears the cycle after the address is registered.

---
 rtl/instruction_fetch_unit_if.sv | 23 ++
 rtl/instruction_fetch_unit.sv | 91 +++++++++
 tb/tb_instruction_fetch_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory address/data plus the decode-facing handshake.
interface instruction_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        halt;
  logic [31:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, instr_out, pc_out, instr_valid, halt, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, instr_out, pc_out, instr_valid, halt, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC/fetch control for a sync-read imem: 1-cycle addr-to-instr latency, stall holds and re-reads the presented word.
// Zero-bubble branch redirect, sticky halt on address overrun; IFU_HALT_DETECT_EN also halts on an accepted all-ones word.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] ADDR_MAX = 32'd1024
) (
  input  logic                      clk,
  input  logic                      rst,
  instruction_fetch_unit_if.master  fetch
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] issued_pc_q;
  logic        issued_valid_q;
  logic [31:0] fetch_count_q;

  logic        valid;
  logic        accept;
  logic        halt_hit;
  logic [31:0] imem_addr_d;

  assign valid  = issued_valid_q && (state_q != HALT);
  assign accept = valid && !fetch.stall;

`ifdef IFU_HALT_DETECT_EN
  assign halt_hit = accept && (fetch.imem_data == 32'hFFFF_FFFF);
`else
  assign halt_hit = 1'b0;
`endif

  // Stall re-reads the issued word so imem_data stays stable across the stall.
  always_comb begin
    imem_addr_d = pc_q;
    if (state_q == HALT) begin
      imem_addr_d = issued_pc_q;
    end else if (fetch.branch_taken) begin
      imem_addr_d = fetch.branch_target;
    end else if (fetch.stall) begin
      imem_addr_d = issued_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      issued_pc_q    <= RESET_PC;
      issued_valid_q <= 1'b0;
      fetch_count_q  <= 32'd0;
    end else if (state_q != HALT) begin
      if (accept) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (halt_hit) begin
        state_q        <= HALT;
        issued_valid_q <= 1'b0;
      end else if (fetch.branch_taken) begin
        if (fetch.branch_target > ADDR_MAX) begin
          state_q        <= HALT;
          issued_valid_q <= 1'b0;
        end else begin
          issued_pc_q    <= fetch.branch_target;
          pc_q           <= fetch.branch_target + 32'd1;
          issued_valid_q <= 1'b1;
          state_q        <= RUN;
        end
      end else if (!fetch.stall) begin
        if (pc_q > ADDR_MAX) begin
          state_q        <= HALT;
          issued_valid_q <= 1'b0;
        end else begin
          issued_pc_q    <= pc_q;
          pc_q           <= pc_q + 32'd1;
          issued_valid_q <= 1'b1;
          state_q        <= RUN;
        end
      end
    end
  end

  assign fetch.imem_addr   = imem_addr_d;
  assign fetch.instr_valid = valid;
  assign fetch.instr_out   = valid ? fetch.imem_data : 32'd0;
  assign fetch.pc_out      = issued_pc_q;
  assign fetch.halt        = (state_q == HALT);
  assign fetch.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed table, hand sequences, then random stimulus against a reference model.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_unit_if ifb ();
  instruction_fetch_unit_if ifs ();

  instruction_fetch_unit #(.RESET_PC(32'd0), .ADDR_MAX(32'd1024)) dut_b (.clk(clk), .rst(rst), .fetch(ifb));
  instruction_fetch_unit #(.RESET_PC(32'd0), .ADDR_MAX(32'd3))    dut_s (.clk(clk), .rst(rst), .fetch(ifs));

  logic [31:0] mem [0:2047];

  always @(posedge clk) begin
    ifb.imem_data <= mem[ifb.imem_addr[10:0]];
    ifs.imem_data <= mem[ifs.imem_addr[10:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what each instance should be presenting, by plain fetch rules.
  bit          m_halt  [2];
  bit          m_valid [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_next  [2];
  logic [31:0] m_cnt   [2];
  logic [31:0] amax    [2];

  typedef struct {
    bit          stall;
    bit          br;
    logic [31:0] tgt;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
    bit          e_halt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(bit s, bit b, logic [31:0] t, bit v, logic [31:0] p, logic [31:0] c, bit h);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.e_valid = v; r.e_pc = p; r.e_cnt = c; r.e_halt = h;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_halt[k] = 0; m_valid[k] = 0; m_pc[k] = 32'd0; m_next[k] = 32'd0; m_cnt[k] = 32'd0;
    end
  endtask

  task automatic model_step(int k, bit s, bit b, logic [31:0] t);
    bit acc;
    bit hit;
    if (m_halt[k]) return;
    acc = m_valid[k] && !s;
    hit = 0;
    if (acc) m_cnt[k] = m_cnt[k] + 32'd1;
`ifdef IFU_HALT_DETECT_EN
    hit = acc && (mem[m_pc[k][10:0]] == 32'hFFFF_FFFF);
`endif
    if (hit) begin
      m_halt[k] = 1;
    end else if (b) begin
      if (t > amax[k]) m_halt[k] = 1;
      else begin m_pc[k] = t; m_next[k] = t + 32'd1; m_valid[k] = 1; end
    end else if (!s) begin
      if (m_next[k] > amax[k]) m_halt[k] = 1;
      else begin m_pc[k] = m_next[k]; m_next[k] = m_next[k] + 32'd1; m_valid[k] = 1; end
    end
  endtask

  task automatic check_dut(int k, string tag, bit ev, logic [31:0] epc, logic [31:0] ecnt, bit eh);
    logic        v, h;
    logic [31:0] o, p, c;
    if (k == 0) begin
      v = ifb.instr_valid; h = ifb.halt; o = ifb.instr_out; p = ifb.pc_out; c = ifb.fetch_count;
    end else begin
      v = ifs.instr_valid; h = ifs.halt; o = ifs.instr_out; p = ifs.pc_out; c = ifs.fetch_count;
    end
    chk({tag, ".valid"}, {31'd0, v}, {31'd0, ev});
    chk({tag, ".instr"}, o, ev ? mem[epc[10:0]] : 32'd0);
    chk({tag, ".pc"},    p, epc);
    chk({tag, ".count"}, c, ecnt);
    chk({tag, ".halt"},  {31'd0, h}, {31'd0, eh});
  endtask

  task automatic check_model(int k, string tag);
    check_dut(k, tag, m_valid[k] && !m_halt[k], m_pc[k], m_cnt[k], m_halt[k]);
  endtask

  task automatic cyc(bit s, bit b, logic [31:0] t);
    ifb.stall = s; ifb.branch_taken = b; ifb.branch_target = t;
    ifs.stall = s; ifs.branch_taken = b; ifs.branch_target = t;
    @(posedge clk);
    model_step(0, s, b, t);
    model_step(1, s, b, t);
    @(negedge clk);
    check_model(1, "small");
  endtask

  task automatic do_reset(string tag);
    ifb.stall = 0; ifb.branch_taken = 0; ifb.branch_target = 32'd0;
    ifs.stall = 0; ifs.branch_taken = 0; ifs.branch_target = 32'd0;
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_dut(0, {tag, ".big"}, 0, 32'd0, 32'd0, 0);
    check_dut(1, {tag, ".small"}, 0, 32'd0, 32'd0, 0);
    chk({tag, ".imem_addr"}, ifb.imem_addr, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h1000_0000 + i;
    mem[40]  = 32'hFFFF_FFFF;
    mem[100] = 32'hFFFF_FFFF;
    amax[0] = 32'd1024;
    amax[1] = 32'd3;
    model_reset();

    // stall, br, tgt -> valid, pc_out, fetch_count, halt after the edge
    tbl[0]  = mk(0, 0, 32'd0,    1, 32'd0,  32'd0, 0);
    tbl[1]  = mk(0, 0, 32'd0,    1, 32'd1,  32'd1, 0);
    tbl[2]  = mk(1, 0, 32'd0,    1, 32'd1,  32'd1, 0);
    tbl[3]  = mk(1, 0, 32'd0,    1, 32'd1,  32'd1, 0);
    tbl[4]  = mk(1, 0, 32'd0,    1, 32'd1,  32'd1, 0);
    tbl[5]  = mk(0, 0, 32'd0,    1, 32'd2,  32'd2, 0);
    tbl[6]  = mk(0, 0, 32'd0,    1, 32'd3,  32'd3, 0);
    tbl[7]  = mk(0, 0, 32'd0,    1, 32'd4,  32'd4, 0);
    tbl[8]  = mk(0, 1, 32'd2,    1, 32'd2,  32'd5, 0);
    tbl[9]  = mk(0, 1, 32'd10,   1, 32'd10, 32'd6, 0);
    tbl[10] = mk(0, 0, 32'd0,    1, 32'd11, 32'd7, 0);
    tbl[11] = mk(1, 1, 32'd20,   1, 32'd20, 32'd7, 0);
    tbl[12] = mk(0, 0, 32'd0,    1, 32'd21, 32'd8, 0);
    tbl[13] = mk(0, 1, 32'd2000, 0, 32'd21, 32'd9, 1);
    tbl[14] = mk(0, 1, 32'd0,    0, 32'd21, 32'd9, 1);
    tbl[15] = mk(0, 0, 32'd0,    0, 32'd21, 32'd9, 1);

    do_reset("reset");
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].stall, tbl[i].br, tbl[i].tgt);
      check_dut(0, $sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_cnt, tbl[i].e_halt);
    end

    // Reset out of HALT, then refetch from RESET_PC.
    do_reset("rst_halt");
    cyc(0, 0, 32'd0);
    check_dut(0, "refetch0", 1, 32'd0, 32'd0, 0);
    cyc(0, 0, 32'd0);
    cyc(1, 0, 32'd0);
    do_reset("rst_midstall");
    cyc(0, 0, 32'd0);
    check_dut(0, "refetch1", 1, 32'd0, 32'd0, 0);

    // Address overrun on the ADDR_MAX=3 instance; branch in HALT ignored.
    do_reset("rst_small");
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 32'd0);
      check_dut(1, $sformatf("ovr%0d", i), 1, i, i, 0);
    end
    cyc(0, 0, 32'd0);
    check_dut(1, "ovr_halt", 0, 32'd3, 32'd4, 1);
    cyc(0, 1, 32'd0);
    check_dut(1, "ovr_branch", 0, 32'd3, 32'd4, 1);

    // All-ones instruction at address 2.
    mem[2] = 32'hFFFF_FFFF;
    do_reset("rst_ones");
    for (int i = 0; i < 4; i++) cyc(0, 0, 32'd0);
`ifdef IFU_HALT_DETECT_EN
    check_dut(0, "ones_halt", 0, 32'd2, 32'd3, 1);
`else
    check_dut(0, "ones_plain", 1, 32'd3, 32'd3, 0);
`endif
    mem[2] = 32'h1000_0002;

    // Randomized run against the model.
    do_reset("rst_rand");
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      bit s, b;
      logic [31:0] t;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset("rand_rst");
      end else begin
        s = (r < 30);
        b = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0) t = $urandom_range(1025, 40000);
        else t = $urandom_range(0, 60);
        cyc(s, b, t);
        check_model(0, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
